// File: rtl/ahb_sram_pkg.sv
// ============================================================================
// Module      : ahb_sram_pkg
// Description : Shared AHB-Lite codes, FSM state type and sizing helper for
//               the parametrised SRAM slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ahb_sram_pkg;

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] c_HRESP_OKAY    = 2'b00;
    localparam logic [1:0] c_HRESP_ERROR   = 2'b01;

    localparam logic [2:0] c_HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] c_HSIZE_HALF    = 3'b001;
    localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
    localparam logic [2:0] c_HSIZE_DWORD   = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Number of byte-offset address bits within one bus word.
    function automatic int bytes_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_byte_strobe_gen.sv
// ============================================================================
// Module      : ahb_byte_strobe_gen
// Description : Byte-lane strobes from HSIZE and low address bits, plus a
//               flag for oversize or size-misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_byte_strobe_gen
    import ahb_sram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]                            i_hsize,
    input  logic [bytes_log2(DATA_WIDTH)-1:0]     i_addr_lo,
    output logic [DATA_WIDTH/8-1:0]               o_strb,
    output logic                                  o_size_err
);

    localparam int c_NB  = DATA_WIDTH / 8;
    localparam int c_LSB = bytes_log2(DATA_WIDTH);

    logic             w_oversize;
    logic [2:0]       w_eff_size;
    logic [c_LSB-1:0] w_low_mask;
    logic [c_NB-1:0]  w_base_strb;

    // Oversize clamps to full width and misaligned bits are masked, so the
    // strobes stay sane even when the error response is not built.
    always_comb begin
        w_oversize  = (i_hsize > 3'(c_LSB));
        w_eff_size  = w_oversize ? 3'(c_LSB) : i_hsize;
        w_low_mask  = c_LSB'((32'd1 << w_eff_size) - 32'd1);
        w_base_strb = c_NB'((32'd1 << (32'd1 << w_eff_size)) - 32'd1);
        o_strb      = w_base_strb << (i_addr_lo & ~w_low_mask);
        o_size_err  = w_oversize | (|(i_addr_lo & w_low_mask));
    end

endmodule

`default_nettype wire

// File: rtl/ahb_sram_slave.sv
// ============================================================================
// Module      : ahb_sram_slave
// Description : Parametrised AHB-Lite SRAM slave with wait states and an
//               optional two-cycle ERROR response (AHB_SRAM_ERR_RESP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16384,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel_i,
    input  logic                  hready_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic                  hwrite_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic [DATA_WIDTH-1:0] hwdata_i,
    output logic                  hready_o,
    output logic [1:0]            hresp_o,
    output logic [DATA_WIDTH-1:0] hrdata_o
);

    localparam int c_NB    = DATA_WIDTH / 8;
    localparam int c_LSB   = bytes_log2(DATA_WIDTH);
    localparam int c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef AHB_SRAM_ERR_RESP_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif

    state_t                     r_state, w_next_state;
    logic [2:0]                 r_wait_cnt, w_wait_cnt_next;
    logic [c_IDX_W-1:0]         r_idx, w_idx;
    logic                       r_write;
    logic [c_NB-1:0]            r_strb, w_strb;
    logic                       w_size_err, w_range_err, w_illegal;
    logic                       w_can_accept, w_accept;
    logic [ADDR_WIDTH-c_LSB-1:0] w_word_addr;
    logic [DATA_WIDTH-1:0]      r_mem [MEM_DEPTH];

    ahb_byte_strobe_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strobe_gen (
        .i_hsize    (hsize_i),
        .i_addr_lo  (haddr_i[c_LSB-1:0]),
        .o_strb     (w_strb),
        .o_size_err (w_size_err)
    );

    assign w_word_addr = haddr_i[ADDR_WIDTH-1:c_LSB];
    assign w_range_err = 64'(w_word_addr) >= 64'(MEM_DEPTH);
    assign w_illegal   = c_ERR_EN & (w_size_err | w_range_err);
`ifdef AHB_SRAM_ERR_RESP_EN
    assign w_idx = c_IDX_W'(w_word_addr);
`else
    assign w_idx = c_IDX_W'(64'(w_word_addr) % 64'(MEM_DEPTH));
`endif

    // hready_i is only meaningful while this slave is not stalling the bus.
    assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    assign w_accept     = hsel_i & hready_i & w_can_accept &
                          ((htrans_i == c_HTRANS_NONSEQ) || (htrans_i == c_HTRANS_SEQ));

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_strb  <= '0;
        end else if (w_accept) begin
            r_idx   <= w_idx;
            r_write <= hwrite_i;
            r_strb  <= w_strb;
        end
    end

    always_ff @(posedge hclk) begin
        if (r_state == ST_DATA && r_write) begin
            for (int b = 0; b < c_NB; b++) begin
                if (r_strb[b]) r_mem[r_idx][b*8 +: 8] <= hwdata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_wait_cnt <= 3'd1) begin
                    w_next_state    = ST_DATA;
                    w_wait_cnt_next = 3'd0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - 3'd1;
                end
            end
`ifdef AHB_SRAM_ERR_RESP_EN
            ST_ERR1: w_next_state = ST_ERR2;
`endif
            default: begin
                w_next_state = ST_IDLE;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next_state = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next_state    = ST_WAIT;
                        w_wait_cnt_next = 3'(WAIT_STATES);
                    end else begin
                        w_next_state = ST_DATA;
                    end
                end
            end
        endcase
    end

    always_comb begin
        hready_o = 1'b1;
        hresp_o  = c_HRESP_OKAY;
        hrdata_o = '0;
        case (r_state)
            ST_WAIT: hready_o = 1'b0;
            ST_DATA: if (!r_write) hrdata_o = r_mem[r_idx];
`ifdef AHB_SRAM_ERR_RESP_EN
            ST_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = c_HRESP_ERROR;
            end
            ST_ERR2: hresp_o = c_HRESP_ERROR;
`endif
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed bench for ahb_sram_slave across three configurations
//               (32-bit/0 wait, 32-bit/3 wait, 64-bit/0 wait).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb_sram_slave;

`ifdef AHB_SRAM_ERR_RESP_EN
    localparam bit c_ERR = 1'b1;
`else
    localparam bit c_ERR = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hreset;
    logic [2:0]  hsel;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [15:0] haddr;
    logic [63:0] hwdata;
    wire  [2:0]  rdy;
    wire  [1:0]  resp_a, resp_b, resp_c;
    wire  [31:0] rdata_a, rdata_b;
    wire  [63:0] rdata_c;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut_a (
        .hclk(hclk), .hreset(hreset), .hsel_i(hsel[0]), .hready_i(rdy[0]), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .haddr_i(haddr), .hwdata_i(hwdata[31:0]),
        .hready_o(rdy[0]), .hresp_o(resp_a), .hrdata_o(rdata_a));

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(64), .WAIT_STATES(3)) u_dut_b (
        .hclk(hclk), .hreset(hreset), .hsel_i(hsel[1]), .hready_i(rdy[1]), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .haddr_i(haddr), .hwdata_i(hwdata[31:0]),
        .hready_o(rdy[1]), .hresp_o(resp_b), .hrdata_o(rdata_b));

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .MEM_DEPTH(64), .WAIT_STATES(0)) u_dut_c (
        .hclk(hclk), .hreset(hreset), .hsel_i(hsel[2]), .hready_i(rdy[2]), .htrans_i(htrans),
        .hsize_i(hsize), .hwrite_i(hwrite), .haddr_i(haddr), .hwdata_i(hwdata),
        .hready_o(rdy[2]), .hresp_o(resp_c), .hrdata_o(rdata_c));

    typedef struct {
        int          dut;
        bit          wr;
        logic [2:0]  sz;
        logic [15:0] addr;
        logic [63:0] wd;
        logic [63:0] exp_rd;
        logic [1:0]  exp_resp;
        int          exp_waits;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] rd(input int k);
        case (k)
            0:       return {32'h0, rdata_a};
            1:       return {32'h0, rdata_b};
            default: return rdata_c;
        endcase
    endfunction

    function automatic logic [1:0] rsp(input int k);
        case (k)
            0:       return resp_a;
            1:       return resp_b;
            default: return resp_c;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic idle_bus();
        hsel   = 3'b000;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize  = 3'd0;
        haddr  = 16'h0;
    endtask

    task automatic add(input int dut, input bit wr, input logic [2:0] sz, input logic [15:0] addr,
                       input logic [63:0] wd, input logic [63:0] exp_rd, input logic [1:0] exp_resp,
                       input int exp_waits);
        vec_t v;
        v.dut = dut; v.wr = wr; v.sz = sz; v.addr = addr; v.wd = wd;
        v.exp_rd = exp_rd; v.exp_resp = exp_resp; v.exp_waits = exp_waits;
        vecs.push_back(v);
    endtask

    // Single NONSEQ transfer; called one time unit after a rising edge.
    task automatic xfer(input int k, input bit wr, input logic [2:0] sz, input logic [15:0] addr,
                        input logic [63:0] wd, output logic [63:0] rdat, output logic [1:0] resp_first,
                        output logic [1:0] resp_last, output int waits);
        hsel    = 3'b000;
        hsel[k] = 1'b1;
        htrans  = 2'b10;
        hwrite  = wr;
        hsize   = sz;
        haddr   = addr;
        tick();
        idle_bus();
        hwdata     = wd;
        resp_first = rsp(k);
        waits      = 0;
        while (!rdy[k] && waits < 20) begin
            waits++;
            tick();
        end
        rdat      = rd(k);
        resp_last = rsp(k);
        tick();
    endtask

    initial begin
        logic [63:0] rdat;
        logic [1:0]  r_first, r_last;
        int          waits;
        int          n;
        logic [1:0]  e_resp;
        int          e_w1;

        e_resp = c_ERR ? 2'b01 : 2'b00;
        e_w1   = c_ERR ? 1 : 3;

        // Port A: 32-bit, no wait states
        add(0, 1, 3'd2, 16'h0010, 64'hDEADBEEF, 64'h0,        2'b00, 0);
        add(0, 0, 3'd2, 16'h0010, 64'h0,        64'hDEADBEEF, 2'b00, 0);
        add(0, 1, 3'd2, 16'h0020, 64'h00000000, 64'h0,        2'b00, 0);
        add(0, 1, 3'd0, 16'h0021, 64'h11111111, 64'h0,        2'b00, 0);
        add(0, 1, 3'd0, 16'h0023, 64'h22222222, 64'h0,        2'b00, 0);
        add(0, 0, 3'd2, 16'h0020, 64'h0,        64'h22001100, 2'b00, 0);
        add(0, 1, 3'd2, 16'h0030, 64'h12345678, 64'h0,        2'b00, 0);
        add(0, 1, 3'd1, 16'h0032, 64'hCAFEF00D, 64'h0,        2'b00, 0);
        add(0, 0, 3'd0, 16'h0031, 64'h0,        64'hCAFE5678, 2'b00, 0);
        add(0, 1, 3'd1, 16'h0011, 64'hFFFFFFFF, 64'h0,        e_resp, c_ERR ? 1 : 0);
        add(0, 0, 3'd2, 16'h0010, 64'h0,        c_ERR ? 64'hDEADBEEF : 64'hDEADFFFF, 2'b00, 0);
        add(0, 1, 3'd2, 16'h0000, 64'h5A5A5A5A, 64'h0,        2'b00, 0);
        add(0, 1, 3'd2, 16'h0100, 64'h0BADF00D, 64'h0,        e_resp, c_ERR ? 1 : 0);
        add(0, 0, 3'd2, 16'h0000, 64'h0,        c_ERR ? 64'h5A5A5A5A : 64'h0BADF00D, 2'b00, 0);
        add(0, 1, 3'd2, 16'h0040, 64'h00000000, 64'h0,        2'b00, 0);
        add(0, 1, 3'd3, 16'h0040, 64'h77777777, 64'h0,        e_resp, c_ERR ? 1 : 0);
        add(0, 0, 3'd2, 16'h0040, 64'h0,        c_ERR ? 64'h0 : 64'h77777777, 2'b00, 0);
        add(0, 0, 3'd2, 16'h0102, 64'h0,        c_ERR ? 64'h0 : 64'h0BADF00D, e_resp, c_ERR ? 1 : 0);
        // Port B: 32-bit, three wait states
        add(1, 1, 3'd2, 16'h0008, 64'h13579BDF, 64'h0,        2'b00, 3);
        add(1, 0, 3'd0, 16'h000B, 64'h0,        64'h13579BDF, 2'b00, 3);
        add(1, 1, 3'd1, 16'h0009, 64'hFFFFFFFF, 64'h0,        e_resp, e_w1);
        add(1, 0, 3'd2, 16'h0008, 64'h0,        c_ERR ? 64'h13579BDF : 64'h1357FFFF, 2'b00, 3);
        // Port C: 64-bit, no wait states
        add(2, 1, 3'd3, 16'h0008, 64'h0123456789ABCDEF, 64'h0, 2'b00, 0);
        add(2, 0, 3'd2, 16'h000C, 64'h0, 64'h0123456789ABCDEF, 2'b00, 0);
        add(2, 1, 3'd2, 16'h000C, 64'hFFFFFFFF00000000, 64'h0, 2'b00, 0);
        add(2, 1, 3'd0, 16'h000F, 64'h5555555555555555, 64'h0, 2'b00, 0);
        add(2, 0, 3'd3, 16'h0008, 64'h0, 64'h55FFFFFF89ABCDEF, 2'b00, 0);

        hreset = 1'b1;
        hwdata = 64'h0;
        idle_bus();
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_ready[%0d]", k), 64'(rdy[k]), 64'h1);
            check($sformatf("reset_resp[%0d]", k), 64'(rsp(k)), 64'h0);
            check($sformatf("reset_rdata[%0d]", k), rd(k), 64'h0);
        end
        hreset = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i].dut, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd, rdat, r_first, r_last, waits);
            check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rd);
            check($sformatf("vec%0d_resp_first", i), 64'(r_first), 64'(vecs[i].exp_resp));
            check($sformatf("vec%0d_resp_last", i), 64'(r_last), 64'(vecs[i].exp_resp));
            check($sformatf("vec%0d_waits", i), 64'(waits), 64'(vecs[i].exp_waits));
        end

        // Pipelined write then read of the same word with no wait states
        hsel = 3'b001; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0050;
        tick();
        hwdata = 64'hA5A5A5A5;
        hwrite = 1'b0;
        check("pipe_wr_ready", 64'(rdy[0]), 64'h1);
        tick();
        idle_bus();
        check("pipe_rd_ready", 64'(rdy[0]), 64'h1);
        check("pipe_rd_data", rd(0), 64'hA5A5A5A5);
        check("pipe_rd_resp", 64'(resp_a), 64'h0);
        tick();
        check("pipe_idle_rdata", rd(0), 64'h0);

        // Back-to-back write/read with three wait states: four cycles each
        hsel = 3'b010; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0020;
        tick();
        hwdata = 64'h0F0F0F0F;
        hwrite = 1'b0;
        n = 1;
        while (!rdy[1] && n < 20) begin n++; tick(); end
        check("b2b_wr_cycles", 64'(n), 64'd4);
        tick();
        idle_bus();
        n = 1;
        while (!rdy[1] && n < 20) begin n++; tick(); end
        check("b2b_rd_cycles", 64'(n), 64'd4);
        check("b2b_rd_data", rd(1), 64'h0F0F0F0F);
        tick();

        // Reset asserted while a write is stalled in its wait states
        xfer(1, 1'b1, 3'd2, 16'h0030, 64'h11112222, rdat, r_first, r_last, waits);
        hsel = 3'b010; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 16'h0030;
        tick();
        idle_bus();
        hwdata = 64'h99999999;
        check("rst_in_wait_ready", 64'(rdy[1]), 64'h0);
        tick();
        #2;
        hreset = 1'b1;
        #1;
        check("rst_async_ready", 64'(rdy[1]), 64'h1);
        check("rst_async_resp", 64'(resp_b), 64'h0);
        check("rst_async_rdata", rd(1), 64'h0);
        tick();
        tick();
        hreset = 1'b0;
        tick();
        xfer(1, 1'b0, 3'd2, 16'h0030, 64'h0, rdat, r_first, r_last, waits);
        check("rst_mem_kept", rdat, 64'h11112222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
